mmu_bus_arbiter: RTL

//  Sits directly below the core: accepts its instruction-read, data-read and data-write requests.

---
 rtl/mmu_pkg.sv | 36 +++
 rtl/mmu_bus_arbiter_if.sv | 43 ++++
 rtl/mmu_req_slot.sv | 26 ++
 rtl/mmu_bus_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU bus arbiter: FSM states, slot ids,
// slot request record and the fixed-priority slot selector.
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int NUM_SLOTS = 3;

    typedef logic [1:0] slot_id_t;

    localparam slot_id_t SLOT_W  = 2'd0;
    localparam slot_id_t SLOT_DR = 2'd1;
    localparam slot_id_t SLOT_IR = 2'd2;

    // Returned to the core in place of an instruction when the bus never answers
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } slot_req_t;

    function automatic slot_id_t prio_sel(input logic [NUM_SLOTS-1:0] pend);
        if (pend[SLOT_W])
            return SLOT_W;
        else if (pend[SLOT_DR])
            return SLOT_DR;
        else
            return SLOT_IR;
    endfunction

endpackage

// File: rtl/mmu_bus_arbiter_if.sv
// Core-side request/response and memory-bus signals of the arbiter.
// slave: the arbiter's view; master: the core + memory environment.
interface mmu_bus_arbiter_if;

    logic        inst_rden;
    logic [31:0] inst_riaddr;
    logic [31:0] inst_roaddr;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_rden;
    logic [31:0] data_riaddr;
    logic [31:0] data_roaddr;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_wren;
    logic [31:0] data_waddr;
    logic [31:0] data_wdata;
    logic        mem_wait;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport slave (
        input  inst_rden, inst_riaddr, data_rden, data_riaddr,
               data_wren, data_waddr, data_wdata, bus_ack, bus_rdata,
        output inst_roaddr, inst_rvalid, inst_rdata,
               data_roaddr, data_rvalid, data_rdata,
               mem_wait, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

    modport master (
        output inst_rden, inst_riaddr, data_rden, data_riaddr,
               data_wren, data_waddr, data_wdata, bus_ack, bus_rdata,
        input  inst_roaddr, inst_rvalid, inst_rdata,
               data_roaddr, data_rvalid, data_rdata,
               mem_wait, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

endinterface

// File: rtl/mmu_req_slot.sv
// One pending-request slot: captures addr/data on set, drops valid on clear.
module mmu_req_slot
    import mmu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set,
    input  logic      clr,
    input  slot_req_t d,
    output logic      vld,
    output slot_req_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (set) begin
            vld <= 1'b1;
            q   <= d;
        end else if (clr) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/mmu_bus_arbiter.sv
// Serialises core write / data-read / instruction-read requests onto one req/ack bus.
// Optional MMU_INST_BUF_EN adds a one-entry instruction buffer that answers repeat fetches locally.
module mmu_bus_arbiter
    import mmu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    mmu_bus_arbiter_if.slave   io
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NUM_SLOTS-1:0] slot_set, slot_clr, slot_vld;
    slot_req_t [NUM_SLOTS-1:0] slot_d, slot_q;

    state_e   state, state_nxt;
    slot_id_t cur, cur_nxt;
    logic [CNT_W-1:0] tmo_cnt;

    logic mem_wait, cap_en, buf_hit;
    logic xfer_ack, xfer_tmo, xfer_done;
    logic bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic bus_err;

    logic        inst_rvalid, data_rvalid;
    logic [31:0] inst_rdata, inst_roaddr, data_rdata, data_roaddr;

    assign mem_wait = (|slot_vld) || (state != IDLE);
    assign cap_en   = !mem_wait;

`ifdef MMU_INST_BUF_EN
    logic        buf_vld;
    logic [31:0] buf_addr, buf_data;

    // A write to the same word in the hit cycle would make the buffer stale
    assign buf_hit = buf_vld && io.inst_rden && (io.inst_riaddr == buf_addr) &&
                     !(io.data_wren && (io.data_waddr[31:2] == buf_addr[31:2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (xfer_ack && cur == SLOT_IR) begin
            buf_vld  <= 1'b1;
            buf_addr <= slot_q[SLOT_IR].addr;
            buf_data <= io.bus_rdata;
        end else if (bus_req && bus_we && (bus_addr[31:2] == buf_addr[31:2])) begin
            buf_vld  <= 1'b0;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    // Capture only while the core is not frozen
    always_comb begin
        slot_set          = '0;
        slot_set[SLOT_W]  = cap_en && io.data_wren;
        slot_set[SLOT_DR] = cap_en && io.data_rden;
        slot_set[SLOT_IR] = cap_en && io.inst_rden && !buf_hit;
        slot_d            = '0;
        slot_d[SLOT_W]    = '{addr: io.data_waddr,  data: io.data_wdata};
        slot_d[SLOT_DR]   = '{addr: io.data_riaddr, data: 32'h0};
        slot_d[SLOT_IR]   = '{addr: io.inst_riaddr, data: 32'h0};
    end

    always_comb begin
        slot_clr = '0;
        if (xfer_done)
            slot_clr[cur] = 1'b1;
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        mmu_req_slot u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .set   (slot_set[i]),
            .clr   (slot_clr[i]),
            .d     (slot_d[i]),
            .vld   (slot_vld[i]),
            .q     (slot_q[i])
        );
    end

    assign xfer_ack  = (state == XFER) && io.bus_ack;
    assign xfer_tmo  = (state == XFER) && !io.bus_ack &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign xfer_done = xfer_ack || xfer_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= SLOT_W;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
        end
    end

    // IDLE looks at this cycle's captures so REQ rises the cycle after capture
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        case (state)
            IDLE: if (|slot_set) begin
                state_nxt = XFER;
                cur_nxt   = prio_sel(slot_set);
            end
            XFER: if (xfer_done)
                state_nxt = RESP;
            RESP: if (|slot_vld) begin
                state_nxt = XFER;
                cur_nxt   = prio_sel(slot_vld);
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_req   = (state == XFER);
        bus_we    = bus_req && (cur == SLOT_W);
        bus_addr  = bus_req ? slot_q[cur].addr : 32'h0;
        bus_wdata = bus_req ? slot_q[cur].data : 32'h0;
    end

    // Cleared on leaving XFER, so every entry starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (state != XFER)
            tmo_cnt <= '0;
        else if (!io.bus_ack)
            tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus_err <= 1'b0;
        else if (xfer_tmo)
            bus_err <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_rvalid <= 1'b0;
            inst_rdata  <= '0;
            inst_roaddr <= '0;
            data_rvalid <= 1'b0;
            data_rdata  <= '0;
            data_roaddr <= '0;
        end else begin
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            if (xfer_done && cur == SLOT_DR) begin
                data_rvalid <= 1'b1;
                data_rdata  <= xfer_ack ? io.bus_rdata : NOP;
                data_roaddr <= slot_q[SLOT_DR].addr;
            end
            if (xfer_done && cur == SLOT_IR) begin
                inst_rvalid <= 1'b1;
                inst_rdata  <= xfer_ack ? io.bus_rdata : NOP;
                inst_roaddr <= slot_q[SLOT_IR].addr;
            end
`ifdef MMU_INST_BUF_EN
            else if (buf_hit) begin
                inst_rvalid <= 1'b1;
                inst_rdata  <= buf_data;
                inst_roaddr <= buf_addr;
            end
`endif
        end
    end

    assign io.mem_wait    = mem_wait;
    assign io.bus_req     = bus_req;
    assign io.bus_we      = bus_we;
    assign io.bus_addr    = bus_addr;
    assign io.bus_wdata   = bus_wdata;
    assign io.bus_err     = bus_err;
    assign io.inst_rvalid = inst_rvalid;
    assign io.inst_rdata  = inst_rdata;
    assign io.inst_roaddr = inst_roaddr;
    assign io.data_rvalid = data_rvalid;
    assign io.data_rdata  = data_rdata;
    assign io.data_roaddr = data_roaddr;

endmodule
